regfile_sb_pipe: RTL and testbench
==================================

Name: regfile_sb_pipe

Overview:
- Parametrised successor of the single-cycle W-bit, 16-entry register file, for the pipelined ARM core.
- Provides 3 read ports and 2 write ports: port 0 is ALU writeback, port 1 is load writeback.
- Adds a load scoreboard with pending bits, a hazard output and a sticky error flag, plus an R15 PC-read path and a selectable debug read port.
- Sits between decode (reads and issue) and writeback (writes).

Parameters:
- W, 32, data width in bits.
- NREG, 16, number of registers (power of 2, ≥4).
- AW, $clog2(NREG), address width (derived; do not override).
- PC_EN, 1, when 1, reads of address NREG-1 return PC_IN and writes to that address are dropped.

Ports:
- CLK  in  1  clock, rising edge.
- RES  in  1  reset, asynchronous, active-high.
- RA0, RA1, RA2  in  AW  read addresses.
- RE  in  3  read-enable per port; used only for hazard detection.
- RD0, RD1, RD2  out  W  read data, combinational.
- WE0  in  1  ALU write enable.
- WA0  in  AW  ALU write address.
- WD0  in  W  ALU write data.
- WE1  in  1  load write enable.
- WA1  in  AW  load write address.
- WD1  in  W  load write data.
- ISS_EN  in  1  load issued; marks ISS_ADDR pending.
- ISS_ADDR  in  AW  destination register of the issued load.
- PC_IN  in  W  current PC+8, returned on reads of R15.
- HAZ  out  1  stall request.
- PEND  out  NREG  pending bit vector.
- PCNT  out  AW+1  count of outstanding loads.
- ERR  out  1  sticky protocol-error flag.
- DBG_ADDR  in  AW  debug read address.
- DBG_DATA  out  W  debug read data (replaces fixed ro1/ro2 taps).

Behaviour:
- Reset:
  - RES high asynchronously clears all registers, PEND, PCNT and ERR to 0.
  - All RD*/DBG_DATA read 0, except R15, which reads PC_IN when PC_EN=1.
  - HAZ=0 while in reset.
  - RES asserted mid-operation discards any same-edge writes and issues.
- Reads: combinational from the array. RDn = data[RAn], or PC_IN if PC_EN and RAn==NREG-1. Same rules for DBG_DATA.
- Writes: on the rising edge, WE0 writes WD0 to WA0 and WE1 writes WD1 to WA1.
  - WA0==WA1 with both enabled: port 0 wins (ALU result is the younger instruction).
  - PC_EN and address NREG-1: the write is silently dropped.
- Scoreboard, per register, next-state on each edge:
  - ISS_EN && ISS_ADDR==r sets pend[r].
  - Else WE1 && WA1==r clears pend[r].
  - Set has priority over clear on the same register in the same cycle (the new load overrides).
  - PCNT equals popcount(PEND), maintained incrementally: +1 on a set of a clear bit, −1 on a clear of a set bit, net 0 when both occur.
  - Issue to R15 with PC_EN=1 is ignored and sets ERR.
- HAZ is combinational, high when any port n satisfies RE[n] && pend[RAn].
  - HAZ does not look at same-cycle WE1; the consumer stalls one cycle and reads the next cycle.
- ERR sets, and stays set until RES, when any of these occurs:
  - ISS_EN targets an already-pending register not being cleared that cycle.
  - WE0 targets a pending register.
  - WE1 targets a non-pending register.
- Latency:
  - Write-to-read: 1 cycle (read in the cycle after the write edge), unless bypass is enabled.
  - Issue-to-HAZ: 1 cycle.
- Boundaries:
  - All NREG pending: PCNT=NREG, no overflow, since AW+1 bits hold NREG.
  - Clear of the last pending bit: PCNT returns to 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If WEx and WAx==RAn (or DBG_ADDR) in the same cycle, RDn returns the write data combinationally, with port 0 taking priority over port 1. The R15 PC rule still takes precedence. HAZ is unchanged.
- Undefined: reads return pre-edge array contents only.

Decomposition:
- Shared package holds:
  - the address-width function;
  - localparams PC_IDX=NREG-1 and NRD=3;
  - the ERR cause encoding, exposed for the bench.
- One natural sub-module: regfile_scoreboard, which owns PEND, PCNT, ERR and HAZ.
- The top module keeps the data array, write arbitration, the PC mux and the bypass.

Test Plan:
- Reset mid-run: load R1=0xDEADBEEF, assert RES asynchronously between edges → RD0 (RA0=1) is 0 immediately; PCNT=0, ERR=0.
- Dual write collision: WE0=WE1=1, WA0=WA1=3, WD0=0x11, WD1=0x22 → next cycle R3 reads 0x11.
- PC path: write 0x55 to R15, PC_IN=0x108 → RD1 (RA1=15) = 0x108; array R15 unchanged; with PC_EN=0 it reads 0x55.
- Scoreboard:
  - ISS_EN to R4 → next cycle PEND[4]=1, PCNT=1; RA2=4 with RE[2]=1 gives HAZ=1.
  - WE1 to R4 → next cycle HAZ=0, PCNT=0, R4 holds WD1.
- Simultaneous set and clear: R5 pending, ISS_EN to R5 and WE1 to R5 in the same cycle → PEND[5] stays 1, PCNT unchanged, ERR=0.
- Error and bypass:
  - WE0 to pending R6 → ERR=1, sticky until RES.
  - With REGFILE_BYPASS_EN, WE0 to R7=0x77 while RA0=7 → RD0=0x77 in the same cycle.

Source files
------------

// File: rtl/regfile_sb_pipe_pkg.sv
// -----------------------------------------------------------------------------
// regfile_sb_pipe_pkg
// Shared definitions for the pipelined register file and its load scoreboard.
//   addr_width()  : address width for a given register count
//   NRD           : number of architectural read ports
//   DEF_NREG      : default register count
//   PC_IDX        : index of the PC register for the default register count
//   err_cause_e   : bit positions of the individual ERR causes
// -----------------------------------------------------------------------------
package regfile_sb_pipe_pkg;

  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int NRD      = 3;
  localparam int DEF_NREG = 16;
  localparam int PC_IDX   = DEF_NREG - 1;

  // Each cause owns one bit of the scoreboard's cause vector.
  typedef enum logic [1:0] {
    ERR_ISS_PEND   = 2'd0,  // issue to a register that is still pending
    ERR_WE0_PEND   = 2'd1,  // ALU write to a register awaiting a load
    ERR_WE1_NOPEND = 2'd2,  // load writeback with no outstanding load
    ERR_ISS_PC     = 2'd3   // load issued to the PC register
  } err_cause_e;

  localparam int NERR = 4;

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Tracks outstanding loads for the register file.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_iss_en/i_iss_addr : load issue; marks the destination pending
//   i_we0/i_wa0         : ALU writeback (error check only)
//   i_we1/i_wa1         : load writeback; clears the pending bit
//   i_ra/i_re           : read addresses and enables for hazard detection
//   o_pend/o_pcnt       : pending vector and its population count
//   o_err               : sticky protocol error
//   o_haz               : stall request
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_sb_pipe_pkg::*;
#(
  parameter int NREG  = 16,
  parameter int AW    = addr_width(NREG),
  parameter bit PC_EN = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_iss_en,
  input  logic [AW-1:0]          i_iss_addr,
  input  logic                   i_we0,
  input  logic [AW-1:0]          i_wa0,
  input  logic                   i_we1,
  input  logic [AW-1:0]          i_wa1,
  input  logic [NRD-1:0][AW-1:0] i_ra,
  input  logic [NRD-1:0]         i_re,
  output logic [NREG-1:0]        o_pend,
  output logic [AW:0]            o_pcnt,
  output logic                   o_err,
  output logic                   o_haz
);

  localparam logic [AW-1:0] LP_PC = AW'(NREG - 1);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_next;
  logic [AW:0]     r_pcnt;
  logic            r_err;
  logic [NERR-1:0] w_cause;
  logic [NRD-1:0]  w_haz_port;
  logic            w_iss_pc;
  logic            w_iss_ok;
  logic            w_same;
  logic            w_inc;
  logic            w_dec;

  assign w_iss_pc = PC_EN && (i_iss_addr == LP_PC);
  assign w_iss_ok = i_iss_en && !w_iss_pc;
  assign w_same   = i_we1 && (i_wa1 == i_iss_addr);

  // A set on a register also being cleared wins, so the clear is not counted.
  assign w_inc = w_iss_ok && !r_pend[i_iss_addr];
  assign w_dec = i_we1 && r_pend[i_wa1] && !(w_iss_ok && w_same);

  assign w_cause[ERR_ISS_PEND]   = w_iss_ok && r_pend[i_iss_addr] && !w_same;
  assign w_cause[ERR_WE0_PEND]   = i_we0 && r_pend[i_wa0];
  assign w_cause[ERR_WE1_NOPEND] = i_we1 && !r_pend[i_wa1];
  assign w_cause[ERR_ISS_PC]     = i_iss_en && w_iss_pc;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
      logic w_set;
      logic w_clr;
      assign w_set = w_iss_ok && (i_iss_addr == AW'(gi));
      assign w_clr = i_we1 && (i_wa1 == AW'(gi));
      assign w_pend_next[gi] = w_set | (r_pend[gi] & ~w_clr);
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_haz
      assign w_haz_port[gi] = i_re[gi] && r_pend[i_ra[gi]];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend <= '0;
      r_pcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      r_pcnt <= r_pcnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
      r_err  <= r_err | (|w_cause);
    end
  end

  // Pending bits are cleared by reset, so the hazard is low while in reset.
  assign o_haz  = |w_haz_port;
  assign o_pend = r_pend;
  assign o_pcnt = r_pcnt;
  assign o_err  = r_err;

endmodule

// File: rtl/regfile_sb_pipe.sv
// -----------------------------------------------------------------------------
// regfile_sb_pipe
// Register file with 3 read ports, 2 write ports (0 = ALU, 1 = load),
// load scoreboard, R15 PC read path and a debug read port.
//   i_clk, i_res                  : clock, asynchronous active-high reset
//   i_ra0..2, i_re / o_rd0..2     : read addresses, hazard enables, read data
//   i_we0/i_wa0/i_wd0             : ALU writeback
//   i_we1/i_wa1/i_wd1             : load writeback
//   i_iss_en/i_iss_addr           : load issue
//   i_pc_in                       : PC+8 returned on R15 reads when PC_EN=1
//   o_haz/o_pend/o_pcnt/o_err     : scoreboard status
//   i_dbg_addr/o_dbg_data         : debug read port
// Optional macro REGFILE_BYPASS_EN: forward same-cycle write data to reads.
// -----------------------------------------------------------------------------
module regfile_sb_pipe
  import regfile_sb_pipe_pkg::*;
#(
  parameter int W     = 32,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = addr_width(NREG),
  parameter bit PC_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_res,
  input  logic [AW-1:0]   i_ra0,
  input  logic [AW-1:0]   i_ra1,
  input  logic [AW-1:0]   i_ra2,
  input  logic [NRD-1:0]  i_re,
  output logic [W-1:0]    o_rd0,
  output logic [W-1:0]    o_rd1,
  output logic [W-1:0]    o_rd2,
  input  logic            i_we0,
  input  logic [AW-1:0]   i_wa0,
  input  logic [W-1:0]    i_wd0,
  input  logic            i_we1,
  input  logic [AW-1:0]   i_wa1,
  input  logic [W-1:0]    i_wd1,
  input  logic            i_iss_en,
  input  logic [AW-1:0]   i_iss_addr,
  input  logic [W-1:0]    i_pc_in,
  output logic            o_haz,
  output logic [NREG-1:0] o_pend,
  output logic [AW:0]     o_pcnt,
  output logic            o_err,
  input  logic [AW-1:0]   i_dbg_addr,
  output logic [W-1:0]    o_dbg_data
);

  localparam logic [AW-1:0] LP_PC = AW'(NREG - 1);
  localparam int            NTAP  = NRD + 1;  // read ports plus debug tap

  logic [W-1:0]             r_mem [NREG];
  logic [NREG-1:0]          w_wr0;
  logic [NREG-1:0]          w_wr1;
  logic [NTAP-1:0][AW-1:0]  w_raddr;
  logic [NTAP-1:0][W-1:0]   w_rdata;
  logic [NRD-1:0][AW-1:0]   w_ra;

  // Write decode; R15 is read-only while it mirrors the PC.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_wdec
      localparam bit LP_RO = PC_EN && (gi == NREG - 1);
      assign w_wr0[gi] = !LP_RO && i_we0 && (i_wa0 == AW'(gi));
      assign w_wr1[gi] = !LP_RO && i_we1 && (i_wa1 == AW'(gi));
    end
  endgenerate

  // Port 0 is checked first: the ALU result belongs to the younger instruction.
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_wr0[i])      r_mem[i] <= i_wd0;
        else if (w_wr1[i]) r_mem[i] <= i_wd1;
      end
    end
  end

  assign w_raddr = {i_dbg_addr, i_ra2, i_ra1, i_ra0};
  assign w_ra    = {i_ra2, i_ra1, i_ra0};

  generate
    for (genvar gi = 0; gi < NTAP; gi++) begin : g_rd
      logic [W-1:0] w_data;
      always_comb begin
        w_data = r_mem[w_raddr[gi]];
`ifdef REGFILE_BYPASS_EN
        if (i_we0 && (i_wa0 == w_raddr[gi]))      w_data = i_wd0;
        else if (i_we1 && (i_wa1 == w_raddr[gi])) w_data = i_wd1;
`endif
        // The PC view overrides both the array and any forwarded data.
        if (PC_EN && (w_raddr[gi] == LP_PC)) w_data = i_pc_in;
      end
      assign w_rdata[gi] = w_data;
    end
  endgenerate

  assign o_rd0      = w_rdata[0];
  assign o_rd1      = w_rdata[1];
  assign o_rd2      = w_rdata[2];
  assign o_dbg_data = w_rdata[3];

  regfile_scoreboard #(
    .NREG  (NREG),
    .AW    (AW),
    .PC_EN (PC_EN)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_res),
    .i_iss_en   (i_iss_en),
    .i_iss_addr (i_iss_addr),
    .i_we0      (i_we0),
    .i_wa0      (i_wa0),
    .i_we1      (i_we1),
    .i_wa1      (i_wa1),
    .i_ra       (w_ra),
    .i_re       (i_re),
    .o_pend     (o_pend),
    .o_pcnt     (o_pcnt),
    .o_err      (o_err),
    .o_haz      (o_haz)
  );

endmodule

// File: tb/tb_regfile_sb_pipe.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb_pipe
// Directed vectors for regfile_sb_pipe. Two instances share all inputs:
// dut (PC_EN=1) and dut_np (PC_EN=0). Honours REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile_sb_pipe;

  localparam int W    = 32;
  localparam int NREG = 16;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          res;
  logic [AW-1:0] ra0, ra1, ra2, wa0, wa1, ia, dbg;
  logic [2:0]    re;
  logic          we0, we1, iss;
  logic [W-1:0]  wd0, wd1;
  logic [W-1:0]  pc_in;

  logic [W-1:0]    rd0, rd1, rd2, dbg_data;
  logic            haz, err;
  logic [NREG-1:0] pend;
  logic [AW:0]     pcnt;

  logic [W-1:0]    n_rd0, n_rd1, n_rd2, n_dbg;
  logic            n_haz, n_err;
  logic [NREG-1:0] n_pend;
  logic [AW:0]     n_pcnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_sb_pipe #(.W(W), .NREG(NREG), .PC_EN(1'b1)) dut (
    .i_clk(clk), .i_res(res), .i_ra0(ra0), .i_ra1(ra1), .i_ra2(ra2), .i_re(re),
    .o_rd0(rd0), .o_rd1(rd1), .o_rd2(rd2),
    .i_we0(we0), .i_wa0(wa0), .i_wd0(wd0), .i_we1(we1), .i_wa1(wa1), .i_wd1(wd1),
    .i_iss_en(iss), .i_iss_addr(ia), .i_pc_in(pc_in),
    .o_haz(haz), .o_pend(pend), .o_pcnt(pcnt), .o_err(err),
    .i_dbg_addr(dbg), .o_dbg_data(dbg_data)
  );

  regfile_sb_pipe #(.W(W), .NREG(NREG), .PC_EN(1'b0)) dut_np (
    .i_clk(clk), .i_res(res), .i_ra0(ra0), .i_ra1(ra1), .i_ra2(ra2), .i_re(re),
    .o_rd0(n_rd0), .o_rd1(n_rd1), .o_rd2(n_rd2),
    .i_we0(we0), .i_wa0(wa0), .i_wd0(wd0), .i_we1(we1), .i_wa1(wa1), .i_wd1(wd1),
    .i_iss_en(iss), .i_iss_addr(ia), .i_pc_in(pc_in),
    .o_haz(n_haz), .o_pend(n_pend), .o_pcnt(n_pcnt), .o_err(n_err),
    .i_dbg_addr(dbg), .o_dbg_data(n_dbg)
  );

  typedef struct {
    logic          we0; logic [3:0] wa0; logic [31:0] wd0;
    logic          we1; logic [3:0] wa1; logic [31:0] wd1;
    logic          iss; logic [3:0] ia;
    logic [3:0]    ra0, ra1, ra2; logic [2:0] re; logic [3:0] dbg;
    logic [31:0]   e_rd0, e_rd1, e_rd2, e_dbg;
    logic          e_haz; logic [15:0] e_pend; logic [4:0] e_pcnt; logic e_err;
  } vec_t;

  function automatic vec_t mk(
      input logic w0, input logic [3:0] a0, input logic [31:0] d0,
      input logic w1, input logic [3:0] a1, input logic [31:0] d1,
      input logic is, input logic [3:0] isa,
      input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
      input logic [2:0] rep, input logic [3:0] da,
      input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
      input logic [31:0] xd, input logic xh, input logic [15:0] xp,
      input logic [4:0] xc, input logic xe);
    vec_t v;
    v.we0 = w0; v.wa0 = a0; v.wd0 = d0; v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
    v.iss = is; v.ia = isa; v.ra0 = r0; v.ra1 = r1; v.ra2 = r2; v.re = rep; v.dbg = da;
    v.e_rd0 = x0; v.e_rd1 = x1; v.e_rd2 = x2; v.e_dbg = xd;
    v.e_haz = xh; v.e_pend = xp; v.e_pcnt = xc; v.e_err = xe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss = 1'b0;
  endtask

  // One edge, then drop the strobes so post-edge reads show array contents.
  task automatic step();
    @(posedge clk);
    #1 idle();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
  endtask

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1; idle();
    wa0 = '0; wa1 = '0; ia = '0; wd0 = '0; wd1 = '0;
    ra0 = 4'd1; ra1 = 4'd15; ra2 = 4'd0; re = 3'b111; dbg = 4'd15;
    pc_in = 32'h0000_0108;

    tbl[0] = mk(1,1,32'hDEADBEEF, 0,0,0, 0,0, 1,0,2,3'b000, 1,
                32'hDEADBEEF,0,0,32'hDEADBEEF, 0,16'h0000,0,0);
    tbl[1] = mk(1,15,32'h55, 0,0,0, 0,0, 15,15,1,3'b000, 15,
                32'h108,32'h108,32'hDEADBEEF,32'h108, 0,16'h0000,0,0);
    tbl[2] = mk(0,0,0, 0,0,0, 1,4, 0,0,4,3'b100, 1,
                0,0,0,32'hDEADBEEF, 1,16'h0010,1,0);
    tbl[3] = mk(0,0,0, 1,4,32'hCAFE0004, 0,0, 4,0,4,3'b100, 4,
                32'hCAFE0004,0,32'hCAFE0004,32'hCAFE0004, 0,16'h0000,0,0);
    tbl[4] = mk(0,0,0, 0,0,0, 1,5, 5,0,0,3'b001, 3,
                0,0,0,0, 1,16'h0020,1,0);
    tbl[5] = mk(0,0,0, 1,5,32'h5555, 1,5, 5,0,0,3'b001, 5,
                32'h5555,0,0,32'h5555, 1,16'h0020,1,0);
    tbl[6] = mk(0,0,0, 1,5,32'hA5, 1,6, 6,5,0,3'b010, 5,
                0,32'hA5,0,32'hA5, 0,16'h0040,1,0);
    tbl[7] = mk(0,0,0, 0,0,0, 1,7, 7,0,0,3'b001, 0,
                0,0,0,0, 1,16'h00C0,2,0);
    tbl[8] = mk(0,0,0, 1,6,32'h66, 0,0, 6,7,1,3'b111, 6,
                32'h66,0,32'hDEADBEEF,32'h66, 1,16'h0080,1,0);
    tbl[9] = mk(1,2,32'h22, 1,7,32'h77, 0,0, 7,2,1,3'b111, 2,
                32'h77,32'h22,32'hDEADBEEF,32'h22, 0,16'h0000,0,0);

    // Reset state, sampled while reset is still asserted.
    #2;
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_rd1_pc", rd1, 32'h108);
    chk("rst_dbg_pc", dbg_data, 32'h108);
    chk("rst_np_rd1", n_rd1, 32'h0);
    chk("rst_haz", {31'h0, haz}, 32'h0);
    chk("rst_pcnt", {27'h0, pcnt}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    $display("txn reset: rd0=0x%0h rd1=0x%0h pcnt=%0d err=%0b", rd0, rd1, pcnt, err);
    @(negedge clk);
    res = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
      we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
      iss = tbl[i].iss; ia = tbl[i].ia;
      ra0 = tbl[i].ra0; ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
      re = tbl[i].re; dbg = tbl[i].dbg;
      step();
      chk($sformatf("v%0d_rd0", i), rd0, tbl[i].e_rd0);
      chk($sformatf("v%0d_rd1", i), rd1, tbl[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), rd2, tbl[i].e_rd2);
      chk($sformatf("v%0d_dbg", i), dbg_data, tbl[i].e_dbg);
      chk($sformatf("v%0d_haz", i), {31'h0, haz}, {31'h0, tbl[i].e_haz});
      chk($sformatf("v%0d_pend", i), {16'h0, pend}, {16'h0, tbl[i].e_pend});
      chk($sformatf("v%0d_pcnt", i), {27'h0, pcnt}, {27'h0, tbl[i].e_pcnt});
      chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, tbl[i].e_err});
      $display("txn vec%0d: rd0=0x%0h rd1=0x%0h rd2=0x%0h dbg=0x%0h haz=%0b pend=0x%0h pcnt=%0d err=%0b",
               i, rd0, rd1, rd2, dbg_data, haz, pend, pcnt, err);
    end

    // R15 without the PC view holds the value written in vec1.
    ra1 = 4'd15; #1;
    chk("np_r15", n_rd1, 32'h55);
    chk("pc_r15", rd1, 32'h108);
    $display("txn r15: pc_view=0x%0h array_view=0x%0h", rd1, n_rd1);

    // All registers pending, then cleared one by one.
    do_reset();
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      iss = 1'b1; ia = AW'(i);
      step();
    end
    chk("full_np_pcnt", {27'h0, n_pcnt}, 32'd16);
    chk("full_np_pend", {16'h0, n_pend}, 32'h0000FFFF);
    chk("full_np_err", {31'h0, n_err}, 32'h0);
    chk("full_pc_pcnt", {27'h0, pcnt}, 32'd15);
    chk("full_pc_pend", {16'h0, pend}, 32'h00007FFF);
    chk("full_pc_err", {31'h0, err}, 32'h1);
    $display("txn full: np_pcnt=%0d pc_pcnt=%0d pc_err=%0b", n_pcnt, pcnt, err);
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      we1 = 1'b1; wa1 = AW'(i); wd1 = 32'h100 + i;
      step();
      if (i == NREG - 2) chk("drain_np_pcnt1", {27'h0, n_pcnt}, 32'd1);
    end
    dbg = 4'd15; #1;
    chk("drain_np_pcnt0", {27'h0, n_pcnt}, 32'd0);
    chk("drain_np_err", {31'h0, n_err}, 32'h0);
    chk("drain_np_r15", n_dbg, 32'h10F);
    $display("txn drain: np_pcnt=%0d np_err=%0b np_r15=0x%0h", n_pcnt, n_err, n_dbg);

    // Dual write to the same register: port 0 wins.
    do_reset();
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd3; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 4'd3; wd1 = 32'h22;
    ra0 = 4'd3;
    step();
    chk("coll_rd0", rd0, 32'h11);
    chk("coll_err", {31'h0, err}, 32'h1);
    $display("txn collision: r3=0x%0h err=%0b", rd0, err);

    // Issue-to-hazard latency and sticky error from ALU write to pending.
    do_reset();
    @(negedge clk);
    iss = 1'b1; ia = 4'd6; ra0 = 4'd6; re = 3'b001;
    #1 chk("iss_haz_pre", {31'h0, haz}, 32'h0);
    step();
    chk("iss_haz_post", {31'h0, haz}, 32'h1);
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd6; wd0 = 32'h60;
    step();
    chk("we0pend_err", {31'h0, err}, 32'h1);
    repeat (3) step();
    chk("err_sticky", {31'h0, err}, 32'h1);
    do_reset();
    #1 chk("err_cleared", {31'h0, err}, 32'h0);
    $display("txn sticky: err after reset=%0b", err);

    // Asynchronous reset between edges, and writes on a reset edge discarded.
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd1; wd0 = 32'hDEADBEEF;
    we1 = 1'b1; wa1 = 4'd2; wd1 = 32'h2;
    iss = 1'b1; ia = 4'd9;
    ra0 = 4'd1; ra2 = 4'd9; re = 3'b100;
    step();
    chk("pre_rst_rd0", rd0, 32'hDEADBEEF);
    chk("pre_rst_haz", {31'h0, haz}, 32'h1);
    #1 res = 1'b1;
    #1;
    chk("mid_rst_rd0", rd0, 32'h0);
    chk("mid_rst_pcnt", {27'h0, pcnt}, 32'h0);
    chk("mid_rst_err", {31'h0, err}, 32'h0);
    chk("mid_rst_haz", {31'h0, haz}, 32'h0);
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd9; wd0 = 32'h99; iss = 1'b1; ia = 4'd10;
    step();
    @(negedge clk);
    res = 1'b0; ra0 = 4'd9; re = 3'b000;
    #1;
    chk("rst_edge_wr", rd0, 32'h0);
    chk("rst_edge_pend", {16'h0, pend}, 32'h0);
    $display("txn midreset: rd0=0x%0h pend=0x%0h", rd0, pend);

    // Same-cycle read of a register being written.
    do_reset();
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd7; wd0 = 32'h77;
    we1 = 1'b1; wa1 = 4'd8; wd1 = 32'h88;
    ra0 = 4'd7; ra1 = 4'd8; ra2 = 4'd15; dbg = 4'd8;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd0", rd0, 32'h77);
    chk("byp_rd1", rd1, 32'h88);
    chk("byp_dbg", dbg_data, 32'h88);
`else
    chk("nobyp_rd0", rd0, 32'h0);
    chk("nobyp_rd1", rd1, 32'h0);
    chk("nobyp_dbg", dbg_data, 32'h0);
`endif
    chk("byp_pc_rd2", rd2, 32'h108);
    step();
    chk("wr_lat_rd0", rd0, 32'h77);
    chk("wr_lat_rd1", rd1, 32'h88);
    $display("txn bypass: rd0=0x%0h rd1=0x%0h", rd0, rd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
